axi_slv_resp_pop_fsm: RTL and testbench
=======================================

AXI_SLV_RESP_POP_FSM -- requirements
Module: axi_slv_resp_pop_fsm

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning): ID_W, 4, AXI ID width; DATA_W, 256, RDATA width; MAX_BEATS, 256, longest legal R burst in beats.
REQ-002 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-003 Port arst, input, 1: asynchronous, active-high reset.
REQ-004 Port b_fifo_empty, input, 1: B response buffer empty; b_fifo_rdata, input, ID_W+2: head entry {BID,BRESP}, first-word-fall-through.
REQ-005 Port b_fifo_rd_en, output, 1: pop B buffer head this cycle.
REQ-006 Port r_fifo_empty, input, 1: R data buffer empty; r_fifo_rdata, input, ID_W+DATA_W+3: head entry {RID,RDATA,RRESP,RLAST}, first-word-fall-through.
REQ-007 Port r_fifo_rd_en, output, 1: pop R buffer head this cycle.
REQ-008 Ports BID (ID_W), BRESP (2), BVALID (1), outputs; BREADY (1), input: AXI B channel towards master.
REQ-009 Ports RID (ID_W), RDATA (DATA_W), RRESP (2), RLAST (1), RVALID (1), outputs; RREADY (1), input: AXI R channel towards master.
REQ-010 Ports b_done, r_burst_done, output, 1: one-cycle pulses for B handshake and RLAST handshake.
REQ-011 Port r_burst_err, output, 1: sticky flag, R burst exceeded MAX_BEATS without RLAST.
REQ-012 Port r_beat_cnt, output, 8: beats accepted in the current R burst.

Function
REQ-013 B and R paths SHALL be two independent FSMs, states IDLE and SEND; neither path SHALL stall the other.
REQ-014 IDLE: when FIFO not empty, SHALL assert rd_en for one cycle, register head entry into output payload, go SEND; VALID=1 from the next cycle (latency 1).
REQ-015 IDLE with FIFO empty: SHALL stay IDLE, rd_en=0, VALID=0.
REQ-016 SEND: VALID SHALL stay 1 and payload SHALL stay stable until VALID&READY.
REQ-017 SEND with VALID&READY and FIFO not empty: SHALL pop and load next entry same cycle, stay SEND (1 beat/cycle throughput, no bubble).
REQ-018 SEND with VALID&READY and FIFO empty: SHALL go IDLE, VALID=0 next cycle.
REQ-019 rd_en SHALL never be asserted while the corresponding FIFO is empty, and never more than once per transferred beat.
REQ-020 Payload outputs SHALL hold last transferred value while in IDLE.
REQ-021 b_done SHALL pulse the cycle after each BVALID&BREADY; r_burst_done SHALL pulse the cycle after each RVALID&RREADY with RLAST=1.
REQ-022 r_beat_cnt SHALL increment (saturating at 255) on each R handshake with RLAST=0 and clear to 0 on R handshake with RLAST=1.
REQ-023 r_burst_err SHALL set on R handshake with RLAST=0 when r_beat_cnt=MAX_BEATS-1; cleared only by reset.
REQ-024 READY asserted while VALID=0 SHALL have no effect.

Reset
REQ-025 arst=1 SHALL immediately force both FSMs to IDLE and all outputs to 0 (VALIDs, rd_ens, payloads, pulses, r_beat_cnt, r_burst_err).
REQ-026 Reset mid-transfer SHALL discard any popped-but-unaccepted beat; first post-reset pop SHALL be the FIFO head at release.
REQ-027 First rd_en SHALL occur no earlier than the first rising edge after arst deasserts.

Verification
REQ-028 Single B entry {BID=3,BRESP=0}, BREADY=1 -> b_fifo_rd_en one cycle, BVALID=1 next cycle for exactly 1 cycle, b_done the cycle after.
REQ-029 4-beat R burst queued, RREADY=1 -> RVALID high 4 consecutive cycles, RLAST on beat 4, r_beat_cnt 0,1,2,3 then 0, one r_burst_done pulse.
REQ-030 RVALID=1 with RREADY=0 for 5 cycles -> RDATA/RID/RLAST stable, no r_fifo_rd_en, r_fifo_empty changes ignored.
REQ-031 B and R traffic concurrent, BREADY held 0 -> R burst completes unaffected; B waits with BVALID=1.
REQ-032 257 R beats, RLAST=0 throughout (MAX_BEATS=256) -> r_burst_err=1 on beat 256 handshake, stays 1 until arst.
REQ-033 arst pulse while RVALID=1 mid-burst -> RVALID, r_beat_cnt to 0 asynchronously; after release, next FIFO head delivered with latency 1.

Source files
------------

// File: rtl/axi_slv_resp_pop_fsm.sv
// Pops buffered AXI B and R responses and presents them on the slave
// response channels; two independent IDLE/SEND pop engines.
module axi_slv_resp_pop_fsm #(
  parameter int ID_W      = 4,
  parameter int DATA_W    = 256,
  parameter int MAX_BEATS = 256
) (
  input  logic                     clk,
  input  logic                     arst,
  input  logic                     b_fifo_empty,
  input  logic [ID_W+1:0]          b_fifo_rdata,
  output logic                     b_fifo_rd_en,
  input  logic                     r_fifo_empty,
  input  logic [ID_W+DATA_W+2:0]   r_fifo_rdata,
  output logic                     r_fifo_rd_en,
  output logic [ID_W-1:0]          BID,
  output logic [1:0]               BRESP,
  output logic                     BVALID,
  input  logic                     BREADY,
  output logic [ID_W-1:0]          RID,
  output logic [DATA_W-1:0]        RDATA,
  output logic [1:0]               RRESP,
  output logic                     RLAST,
  output logic                     RVALID,
  input  logic                     RREADY,
  output logic                     b_done,
  output logic                     r_burst_done,
  output logic                     r_burst_err,
  output logic [7:0]               r_beat_cnt
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam logic [31:0] LAST_BEAT = 32'(MAX_BEATS - 1);

  state_t b_state;
  state_t b_next;
  state_t r_state;
  state_t r_next;

  logic run;
  logic b_pop;
  logic r_pop;
  logic b_hs;
  logic r_hs;

  // Holds off popping until the first edge after reset release.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      run <= 1'b0;
    end else begin
      run <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      b_state <= IDLE;
      r_state <= IDLE;
    end else begin
      b_state <= b_next;
      r_state <= r_next;
    end
  end

  always_comb begin
    b_next = b_state;
    b_pop  = 1'b0;
    unique case (b_state)
      IDLE: begin
        if (run && !b_fifo_empty) begin
          b_pop  = 1'b1;
          b_next = SEND;
        end
      end
      SEND: begin
        if (BREADY) begin
          if (!b_fifo_empty) begin
            b_pop = 1'b1;
          end else begin
            b_next = IDLE;
          end
        end
      end
    endcase
  end

  always_comb begin
    r_next = r_state;
    r_pop  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (run && !r_fifo_empty) begin
          r_pop  = 1'b1;
          r_next = SEND;
        end
      end
      SEND: begin
        if (RREADY) begin
          if (!r_fifo_empty) begin
            r_pop = 1'b1;
          end else begin
            r_next = IDLE;
          end
        end
      end
    endcase
  end

  assign b_fifo_rd_en = b_pop;
  assign r_fifo_rd_en = r_pop;
  assign BVALID       = (b_state == SEND);
  assign RVALID       = (r_state == SEND);
  assign b_hs         = BVALID & BREADY;
  assign r_hs         = RVALID & RREADY;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      BID   <= '0;
      BRESP <= '0;
    end else if (b_pop) begin
      {BID, BRESP} <= b_fifo_rdata;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      RID   <= '0;
      RDATA <= '0;
      RRESP <= '0;
      RLAST <= 1'b0;
    end else if (r_pop) begin
      {RID, RDATA, RRESP, RLAST} <= r_fifo_rdata;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      b_done       <= 1'b0;
      r_burst_done <= 1'b0;
    end else begin
      b_done       <= b_hs;
      r_burst_done <= r_hs & RLAST;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_beat_cnt <= '0;
    end else if (r_hs) begin
      if (RLAST) begin
        r_beat_cnt <= '0;
      end else if (r_beat_cnt != 8'hFF) begin
        r_beat_cnt <= r_beat_cnt + 8'd1;
      end
    end
  end

  // Sticky until reset: a burst ran past the legal length without RLAST.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_burst_err <= 1'b0;
    end else if (r_hs && !RLAST && (32'(r_beat_cnt) == LAST_BEAT)) begin
      r_burst_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axi_slv_resp_pop_fsm.sv
// Bench for axi_slv_resp_pop_fsm: queue-backed FIFOs, behavioural
// model compared every cycle, directed scenarios plus random traffic.
module tb_axi_slv_resp_pop_fsm;

  localparam int ID_W   = 4;
  localparam int DATA_W = 256;
  localparam int MAXB   = 256;
  localparam int BW     = ID_W + 2;
  localparam int RW     = ID_W + DATA_W + 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              arst;
  logic              b_fifo_empty;
  logic [BW-1:0]     b_fifo_rdata;
  logic              b_fifo_rd_en;
  logic              r_fifo_empty;
  logic [RW-1:0]     r_fifo_rdata;
  logic              r_fifo_rd_en;
  logic [ID_W-1:0]   BID;
  logic [1:0]        BRESP;
  logic              BVALID;
  logic              BREADY;
  logic [ID_W-1:0]   RID;
  logic [DATA_W-1:0] RDATA;
  logic [1:0]        RRESP;
  logic              RLAST;
  logic              RVALID;
  logic              RREADY;
  logic              b_done;
  logic              r_burst_done;
  logic              r_burst_err;
  logic [7:0]        r_beat_cnt;

  axi_slv_resp_pop_fsm #(
    .ID_W(ID_W),
    .DATA_W(DATA_W),
    .MAX_BEATS(MAXB)
  ) dut (
    .clk(clk),
    .arst(arst),
    .b_fifo_empty(b_fifo_empty),
    .b_fifo_rdata(b_fifo_rdata),
    .b_fifo_rd_en(b_fifo_rd_en),
    .r_fifo_empty(r_fifo_empty),
    .r_fifo_rdata(r_fifo_rdata),
    .r_fifo_rd_en(r_fifo_rd_en),
    .BID(BID),
    .BRESP(BRESP),
    .BVALID(BVALID),
    .BREADY(BREADY),
    .RID(RID),
    .RDATA(RDATA),
    .RRESP(RRESP),
    .RLAST(RLAST),
    .RVALID(RVALID),
    .RREADY(RREADY),
    .b_done(b_done),
    .r_burst_done(r_burst_done),
    .r_burst_err(r_burst_err),
    .r_beat_cnt(r_beat_cnt)
  );

  logic [BW-1:0] bq[$];
  logic [RW-1:0] rq[$];

  int checks = 0;
  int failures = 0;

  // Model: what the master currently sees on each channel
  bit            m_run;
  bit            m_bv;
  bit            m_rv;
  bit            m_bdone;
  bit            m_rdone;
  bit            m_err;
  logic [BW-1:0] m_b;
  logic [RW-1:0] m_r;
  int            m_len;

  task automatic chk(input string nm, input logic [RW-1:0] act,
                     input logic [RW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic refresh();
    b_fifo_empty = (bq.size() == 0);
    b_fifo_rdata = (bq.size() > 0) ? bq[0] : '1;
    r_fifo_empty = (rq.size() == 0);
    r_fifo_rdata = (rq.size() > 0) ? rq[0] : '1;
  endtask

  task automatic push_b(input int id, input int resp);
    bq.push_back({ID_W'(id), 2'(resp)});
    refresh();
  endtask

  task automatic push_r(input int id, input bit last);
    logic [DATA_W-1:0] d;
    for (int k = 0; k < DATA_W / 32; k++) d[k*32 +: 32] = $urandom;
    rq.push_back({ID_W'(id), d, 2'($urandom_range(0, 3)), last});
    refresh();
  endtask

  task automatic model_clear();
    m_run   = 0;
    m_bv    = 0;
    m_rv    = 0;
    m_bdone = 0;
    m_rdone = 0;
    m_err   = 0;
    m_b     = '0;
    m_r     = '0;
    m_len   = 0;
  endtask

  task automatic compare();
    bit ebr;
    bit err;
    #1;
    ebr = !arst && m_run && bq.size() > 0 && (!m_bv || BREADY);
    err = !arst && m_run && rq.size() > 0 && (!m_rv || RREADY);
    chk("bvalid", BVALID, m_bv);
    chk("bpayload", {BID, BRESP}, m_b);
    chk("b_rd_en", b_fifo_rd_en, ebr);
    chk("b_done", b_done, m_bdone);
    chk("rvalid", RVALID, m_rv);
    chk("rpayload", {RID, RDATA, RRESP, RLAST}, m_r);
    chk("r_rd_en", r_fifo_rd_en, err);
    chk("r_burst_done", r_burst_done, m_rdone);
    chk("r_beat_cnt", r_beat_cnt, (m_len > 255) ? 255 : m_len);
    chk("r_burst_err", r_burst_err, m_err);
  endtask

  task automatic advance();
    bit bpa;
    bit rpa;
    bit bhs;
    bit rhs;
    bit rl;
    bpa = b_fifo_rd_en;
    rpa = r_fifo_rd_en;
    if (arst) begin
      model_clear();
    end else begin
      bhs = m_bv && BREADY;
      m_bdone = bhs;
      if (m_run && bq.size() > 0 && (!m_bv || bhs)) begin
        m_b  = bq[0];
        m_bv = 1;
      end else if (bhs) begin
        m_bv = 0;
      end
      rhs = m_rv && RREADY;
      rl = m_r[0];
      m_rdone = rhs && rl;
      if (rhs) begin
        if (rl) begin
          m_len = 0;
        end else begin
          m_len++;
          if (m_len == MAXB) m_err = 1;
        end
      end
      if (m_run && rq.size() > 0 && (!m_rv || rhs)) begin
        m_r  = rq[0];
        m_rv = 1;
      end else if (rhs) begin
        m_rv = 0;
      end
      m_run = 1;
    end
    @(posedge clk);
    if (bpa && bq.size() > 0) void'(bq.pop_front());
    if (rpa && rq.size() > 0) void'(rq.pop_front());
    @(negedge clk);
    refresh();
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      compare();
      advance();
    end
  endtask

  initial begin
    int hs;
    int dn;
    logic [RW-1:0] snap;
    arst   = 1'b1;
    BREADY = 1'b0;
    RREADY = 1'b0;
    model_clear();
    refresh();
    @(negedge clk);
    #1;
    chk("rst_bvalid", BVALID, 0);
    chk("rst_rvalid", RVALID, 0);
    chk("rst_rdata", RDATA, 0);
    chk("rst_cnt", r_beat_cnt, 0);
    run_cycles(2);

    // Single B entry, entry already waiting when reset releases
    push_b(3, 0);
    BREADY = 1'b1;
    compare();
    chk("b_rd_in_rst", b_fifo_rd_en, 0);
    advance();
    arst = 1'b0;
    compare();
    chk("b_rd_before_edge", b_fifo_rd_en, 0);
    advance();
    compare();
    chk("b28_rd_en", b_fifo_rd_en, 1);
    chk("b28_valid0", BVALID, 0);
    advance();
    compare();
    chk("b28_valid1", BVALID, 1);
    chk("b28_payload", {BID, BRESP}, 6'b0011_00);
    chk("b28_no_rd", b_fifo_rd_en, 0);
    advance();
    compare();
    chk("b28_valid2", BVALID, 0);
    chk("b28_done", b_done, 1);
    advance();
    compare();
    chk("b28_done_off", b_done, 0);
    advance();

    // 4-beat R burst with RREADY held
    RREADY = 1'b1;
    for (int i = 0; i < 4; i++) push_r(5, i == 3);
    for (int i = 0; i < 6; i++) begin
      compare();
      chk("r29_valid", RVALID, (i >= 1 && i <= 4));
      if (i >= 1 && i <= 4) begin
        chk("r29_cnt", r_beat_cnt, i - 1);
        chk("r29_last", RLAST, i == 4);
      end
      if (i == 5) begin
        chk("r29_cnt_clr", r_beat_cnt, 0);
        chk("r29_done", r_burst_done, 1);
      end
      advance();
    end

    // Stall: payload must hold, FIFO changes ignored
    RREADY = 1'b0;
    push_r(7, 1);
    for (int i = 0; i < 4 && !RVALID; i++) begin
      compare();
      advance();
    end
    chk("r30_valid_up", RVALID, 1);
    snap = {RID, RDATA, RRESP, RLAST};
    for (int i = 0; i < 5; i++) begin
      if (i % 2 == 0) push_r(i, 1);
      compare();
      chk("r30_stable", {RID, RDATA, RRESP, RLAST}, snap);
      chk("r30_no_pop", r_fifo_rd_en, 0);
      advance();
    end
    RREADY = 1'b1;
    run_cycles(6);

    // Concurrent B held off while an R burst runs
    BREADY = 1'b0;
    push_b(9, 2);
    for (int i = 0; i < 3; i++) push_r(2, i == 2);
    dn = 0;
    for (int i = 0; i < 8; i++) begin
      compare();
      dn += r_burst_done;
      advance();
    end
    chk("r31_bvalid", BVALID, 1);
    chk("r31_bid", BID, 9);
    chk("r31_rdone", dn, 1);
    chk("r31_rempty", RVALID, 0);
    BREADY = 1'b1;
    run_cycles(3);

    // Over-long burst without RLAST
    for (int i = 0; i < 257; i++) push_r(1, 0);
    hs = 0;
    for (int i = 0; i < 270; i++) begin
      compare();
      if (RVALID && RREADY) hs++;
      advance();
      if (hs == 255 && RVALID) chk("r32_err_255", r_burst_err, 0);
      if (hs == 256 && RVALID) chk("r32_err_256", r_burst_err, 1);
    end
    chk("r32_beats", hs, 257);
    chk("r32_sticky", r_burst_err, 1);
    chk("r32_cnt_sat", r_beat_cnt, 255);
    arst = 1'b1;
    model_clear();
    #1;
    chk("r32_err_clr", r_burst_err, 0);
    advance();
    arst = 1'b0;
    run_cycles(1);

    // Reset in the middle of a burst
    for (int i = 0; i < 5; i++) push_r(6, i == 4);
    run_cycles(3);
    chk("r33_pre_cnt", r_beat_cnt, 2);
    arst = 1'b1;
    model_clear();
    #1;
    chk("r33_rvalid", RVALID, 0);
    chk("r33_cnt", r_beat_cnt, 0);
    chk("r33_rd_en", r_fifo_rd_en, 0);
    advance();
    arst = 1'b0;
    snap = rq[0];
    compare();
    advance();
    compare();
    chk("r33_pop", r_fifo_rd_en, 1);
    advance();
    compare();
    chk("r33_head", {RID, RDATA, RRESP, RLAST}, snap);
    chk("r33_valid", RVALID, 1);
    advance();
    run_cycles(6);

    // Random traffic with occasional reset
    for (int c = 0; c < 3000; c++) begin
      BREADY = ($urandom_range(0, 3) != 0);
      RREADY = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0) push_b($urandom_range(0, 15), $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0) push_r($urandom_range(0, 15), $urandom_range(0, 3) == 0);
      if ($urandom_range(0, 299) == 0) begin
        arst = 1'b1;
        model_clear();
      end else begin
        arst = 1'b0;
      end
      compare();
      advance();
    end
    arst = 1'b0;
    BREADY = 1'b1;
    RREADY = 1'b1;
    run_cycles(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
